ahb3lite_slave_arbiter: RTL and testbench

//  Shares one AHB3-Lite slave port (e.g. a single-port SRAM) between MASTERS AHB masters (instr + data fetch).

---
 rtl/ahb3lite_arb_pkg.sv | 17 +
 rtl/ahb_rr_arbiter_core.sv | 27 ++
 rtl/ahb3lite_slave_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ahb3lite_slave_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_arb_pkg.sv
// Shared AHB3-Lite encodings and arbiter state type for the slave-port arbiter.
package ahb3lite_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic {
        StIdle,
        StOwned
    } arb_state_t;

endpackage

// File: rtl/ahb_rr_arbiter_core.sv
// Masked round-robin picker: first requester at or above ptr wins, else lowest requester.
// Holding ptr at zero turns it into a fixed-priority arbiter (index 0 highest).
module ahb_rr_arbiter_core #(
    parameter int unsigned MASTERS = 2,
    localparam int unsigned IW     = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic [MASTERS-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [MASTERS-1:0] gnt
);

    logic [MASTERS-1:0] mask;
    logic [MASTERS-1:0] masked;
    logic [MASTERS-1:0] pick;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MASTERS; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = req & mask;
        pick   = (|masked) ? masked : req;
        // isolate lowest set bit
        gnt    = pick & (~pick + MASTERS'(1));
    end

endmodule

// File: rtl/ahb3lite_slave_arbiter.sv
// Shares one AHB3-Lite slave port between several masters; bursts and locked
// sequences keep their grant, losers are stalled through their HREADYOUT.
module ahb3lite_slave_arbiter
    import ahb3lite_arb_pkg::*;
#(
    parameter int unsigned MASTERS    = 2,
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned ARB_RR     = 1,
    localparam int unsigned IW        = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                           HCLK,
    input  logic                           HRESET,

    input  logic [MASTERS-1:0]             mst_HSEL,
    input  logic [2*MASTERS-1:0]           mst_HTRANS,
    input  logic [HADDR_SIZE*MASTERS-1:0]  mst_HADDR,
    input  logic [MASTERS-1:0]             mst_HWRITE,
    input  logic [3*MASTERS-1:0]           mst_HSIZE,
    input  logic [3*MASTERS-1:0]           mst_HBURST,
    input  logic [4*MASTERS-1:0]           mst_HPROT,
    input  logic [MASTERS-1:0]             mst_HMASTLOCK,
    input  logic [HDATA_SIZE*MASTERS-1:0]  mst_HWDATA,
    output logic [MASTERS-1:0]             mst_HREADYOUT,
    output logic [MASTERS-1:0]             mst_HRESP,
    output logic [HDATA_SIZE-1:0]          mst_HRDATA,

    output logic                           slv_HSEL,
    output logic [1:0]                     slv_HTRANS,
    output logic [HADDR_SIZE-1:0]          slv_HADDR,
    output logic                           slv_HWRITE,
    output logic [2:0]                     slv_HSIZE,
    output logic [2:0]                     slv_HBURST,
    output logic [3:0]                     slv_HPROT,
    output logic                           slv_HMASTLOCK,
    output logic [HDATA_SIZE-1:0]          slv_HWDATA,
    output logic                           slv_HREADY,
    input  logic                           slv_HREADYOUT,
    input  logic                           slv_HRESP,
    input  logic [HDATA_SIZE-1:0]          slv_HRDATA,

    output logic [IW-1:0]                  grant_o
);

    arb_state_t          state_q;
    logic [IW-1:0]       owner_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       d_owner_q;
    logic                d_valid_q;

    logic [MASTERS-1:0]  req;
    logic [MASTERS-1:0]  gnt;
    logic [IW-1:0]       gnt_idx;
    logic [IW-1:0]       cur_owner;
    logic                cur_valid;
    logic [1:0]          own_trans;
    logic                own_lock;
    logic                hold;
    logic                arb_ok;
    logic                arb_now;
    logic                nonseq_done;

    always_comb begin
        req       = '0;
        gnt_idx   = '0;
        own_trans = HTRANS_IDLE;
        own_lock  = 1'b0;
        for (int m = 0; m < MASTERS; m++) begin
            req[m] = mst_HSEL[m] & mst_HTRANS[2*m+1];
            if (gnt[m]) gnt_idx = IW'(m);
            if (owner_q == IW'(m)) begin
                own_trans = mst_HTRANS[2*m +: 2];
                own_lock  = mst_HMASTLOCK[m];
            end
        end
    end

    ahb_rr_arbiter_core #(
        .MASTERS (MASTERS)
    ) u_core (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // A burst in progress or a locked sequence keeps the bus with its owner.
    assign hold    = (state_q == StOwned) &&
                     (own_trans == HTRANS_SEQ || own_trans == HTRANS_BUSY || own_lock);
    assign arb_ok  = slv_HREADYOUT | ~d_valid_q;
    assign arb_now = ~HRESET & arb_ok & ~hold;

    // Newly arbitrated owner is used in the same cycle, so uncontended access adds no latency.
    always_comb begin
        cur_owner = owner_q;
        cur_valid = (state_q == StOwned);
        if (HRESET) begin
            cur_owner = '0;
            cur_valid = 1'b0;
        end else if (arb_now) begin
            cur_owner = gnt_idx;
            cur_valid = |gnt;
        end
    end

    assign grant_o = cur_owner;

    always_comb begin
        slv_HSEL      = 1'b0;
        slv_HTRANS    = HTRANS_IDLE;
        slv_HADDR     = '0;
        slv_HWRITE    = 1'b0;
        slv_HSIZE     = '0;
        slv_HBURST    = '0;
        slv_HPROT     = '0;
        slv_HMASTLOCK = 1'b0;
        slv_HWDATA    = '0;
        for (int m = 0; m < MASTERS; m++) begin
            if (cur_valid && cur_owner == IW'(m)) begin
                slv_HSEL      = mst_HSEL[m];
                slv_HTRANS    = mst_HTRANS[2*m +: 2];
                slv_HADDR     = mst_HADDR[HADDR_SIZE*m +: HADDR_SIZE];
                slv_HWRITE    = mst_HWRITE[m];
                slv_HSIZE     = mst_HSIZE[3*m +: 3];
                slv_HBURST    = mst_HBURST[3*m +: 3];
                slv_HPROT     = mst_HPROT[4*m +: 4];
                slv_HMASTLOCK = mst_HMASTLOCK[m];
            end
            if (d_owner_q == IW'(m)) begin
                slv_HWDATA = mst_HWDATA[HDATA_SIZE*m +: HDATA_SIZE];
            end
        end
    end

    assign slv_HREADY = slv_HREADYOUT;
    assign mst_HRDATA = slv_HRDATA;

    always_comb begin
        mst_HREADYOUT = '1;
        mst_HRESP     = {MASTERS{HRESP_OKAY}};
        if (!HRESET) begin
            for (int m = 0; m < MASTERS; m++) begin
                if (d_valid_q && d_owner_q == IW'(m)) begin
                    mst_HREADYOUT[m] = slv_HREADYOUT;
                    mst_HRESP[m]     = slv_HRESP ? HRESP_ERROR : HRESP_OKAY;
                end else if (cur_valid && cur_owner == IW'(m)) begin
                    mst_HREADYOUT[m] = slv_HREADYOUT;
                end else if (req[m]) begin
                    mst_HREADYOUT[m] = 1'b0;
                end
            end
        end
    end

    assign nonseq_done = cur_valid & slv_HREADYOUT & slv_HSEL & (slv_HTRANS == HTRANS_NONSEQ);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= StIdle;
            owner_q   <= '0;
            ptr_q     <= '0;
            d_owner_q <= '0;
            d_valid_q <= 1'b0;
        end else begin
            if (arb_now) begin
                state_q <= (|gnt) ? StOwned : StIdle;
                owner_q <= gnt_idx;
            end
            if (ARB_RR != 0 && nonseq_done) begin
                ptr_q <= (cur_owner == IW'(MASTERS - 1)) ? '0 : cur_owner + IW'(1);
            end
            if (slv_HREADYOUT) begin
                d_valid_q <= cur_valid & slv_HSEL & (slv_HTRANS != HTRANS_IDLE);
                d_owner_q <= cur_owner;
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_slave_arbiter.sv
// Bench for the two-master slave-port arbiter: a scoreboard of expected slave-side
// address phases plus per-cycle checks of stall, response and routing behaviour.
module tb_ahb3lite_slave_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  m_sel;
    logic [3:0]  m_trans;
    logic [63:0] m_addr;
    logic [1:0]  m_write;
    logic [5:0]  m_size;
    logic [5:0]  m_burst;
    logic [7:0]  m_prot;
    logic [1:0]  m_lock;
    logic [63:0] m_wdata;
    logic [1:0]  m_readyout;
    logic [1:0]  m_resp;
    logic [31:0] m_rdata;
    logic        s_sel;
    logic [1:0]  s_trans;
    logic [31:0] s_addr;
    logic        s_write;
    logic [2:0]  s_size;
    logic [2:0]  s_burst;
    logic [3:0]  s_prot;
    logic        s_lock;
    logic [31:0] s_wdata;
    logic        s_ready;
    logic        s_readyout;
    logic        s_resp;
    logic [31:0] s_rdata;
    logic        grant;

    typedef struct {
        int unsigned m;
        logic [31:0] addr;
        logic        write;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    ahb3lite_slave_arbiter #(
        .MASTERS    (2),
        .HADDR_SIZE (32),
        .HDATA_SIZE (32),
        .ARB_RR     (1)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .mst_HSEL      (m_sel),
        .mst_HTRANS    (m_trans),
        .mst_HADDR     (m_addr),
        .mst_HWRITE    (m_write),
        .mst_HSIZE     (m_size),
        .mst_HBURST    (m_burst),
        .mst_HPROT     (m_prot),
        .mst_HMASTLOCK (m_lock),
        .mst_HWDATA    (m_wdata),
        .mst_HREADYOUT (m_readyout),
        .mst_HRESP     (m_resp),
        .mst_HRDATA    (m_rdata),
        .slv_HSEL      (s_sel),
        .slv_HTRANS    (s_trans),
        .slv_HADDR     (s_addr),
        .slv_HWRITE    (s_write),
        .slv_HSIZE     (s_size),
        .slv_HBURST    (s_burst),
        .slv_HPROT     (s_prot),
        .slv_HMASTLOCK (s_lock),
        .slv_HWDATA    (s_wdata),
        .slv_HREADY    (s_ready),
        .slv_HREADYOUT (s_readyout),
        .slv_HRESP     (s_resp),
        .slv_HRDATA    (s_rdata),
        .grant_o       (grant)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic lk, input logic [31:0] wd);
        m_sel[m]          = (tr != 2'b00);
        m_trans[m*2 +: 2] = tr;
        m_addr[m*32 +: 32] = a;
        m_write[m]        = w;
        m_lock[m]         = lk;
        m_wdata[m*32 +: 32] = wd;
    endtask

    task automatic slv(input logic rdy, input logic rsp, input logic [31:0] rd);
        s_readyout = rdy;
        s_resp     = rsp;
        s_rdata    = rd;
    endtask

    task automatic push(input int unsigned m, input logic [31:0] a, input logic w);
        exp_t x;
        x.m = m;
        x.addr = a;
        x.write = w;
        exp_q.push_back(x);
    endtask

    task automatic idle_all();
        drv(0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        drv(1, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Every accepted slave address phase must match the oldest expected transfer.
    always @(negedge HCLK) begin
        if (!HRESET && s_sel && s_trans[1] && s_readyout) begin
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("xfer_owner", {31'd0, grant}, e.m);
                check("xfer_addr", s_addr, e.addr);
                check("xfer_write", {31'd0, s_write}, {31'd0, e.write});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET = 1'b1;
        m_sel = '0; m_trans = '0; m_addr = '0; m_write = '0; m_lock = '0; m_wdata = '0;
        m_size = '0; m_burst = '0; m_prot = '0;
        slv(1'b1, 1'b0, 32'h0);
        tick();
        tick();
        mid();
        check("rst_readyout", {30'd0, m_readyout}, 32'h3);
        check("rst_resp", {30'd0, m_resp}, 32'h0);
        check("rst_htrans", {30'd0, s_trans}, 32'h0);
        check("rst_hsel", {31'd0, s_sel}, 32'h0);
        check("rst_grant", {31'd0, grant}, 32'h0);
        tick();
        HRESET = 1'b0;

        // Contention with pointer at 0: m0 first, m1 stalled one cycle.
        drv(0, 2'b10, 32'h200, 1'b1, 1'b0, 32'hAAAA_0200);
        drv(1, 2'b10, 32'h300, 1'b0, 1'b0, 32'h0);
        push(0, 32'h200, 1'b1);
        mid();
        check("cont_grant0", {31'd0, grant}, 32'd0);
        check("cont_m1_stall", {30'd0, m_readyout}, 32'h1);
        tick();
        drv(0, 2'b00, 32'h0, 1'b0, 1'b0, 32'hAAAA_0200);
        push(1, 32'h300, 1'b0);
        mid();
        check("cont_grant1", {31'd0, grant}, 32'd1);
        check("cont_ready", {30'd0, m_readyout}, 32'h3);
        check("cont_hwdata", s_wdata, 32'hAAAA_0200);
        tick();
        drv(1, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        slv(1'b1, 1'b0, 32'h1234_0300);
        mid();
        check("cont_rdata", m_rdata, 32'h1234_0300);
        check("cont_idle", {30'd0, s_trans}, 32'h0);
        tick();

        // Single uncontended read: address visible in the same cycle.
        drv(0, 2'b10, 32'h100, 1'b0, 1'b0, 32'h0);
        push(0, 32'h100, 1'b0);
        mid();
        check("single_haddr", s_addr, 32'h100);
        check("single_ready", {30'd0, m_readyout}, 32'h3);
        tick();
        drv(0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        slv(1'b1, 1'b0, 32'hCAFE_0100);
        mid();
        check("single_rdata", m_rdata, 32'hCAFE_0100);
        check("single_resp", {30'd0, m_resp}, 32'h0);
        tick();

        // INCR4 burst by m0 is not broken by m1's request.
        drv(0, 2'b10, 32'h400, 1'b0, 1'b0, 32'h0);
        push(0, 32'h400, 1'b0);
        mid();
        check("burst_nonseq_ready", {30'd0, m_readyout}, 32'h3);
        tick();
        drv(1, 2'b10, 32'h500, 1'b0, 1'b0, 32'h0);
        for (int b = 1; b < 4; b++) begin
            drv(0, 2'b11, 32'h400 + 32'(4*b), 1'b0, 1'b0, 32'h0);
            push(0, 32'h400 + 32'(4*b), 1'b0);
            mid();
            check("burst_grant", {31'd0, grant}, 32'd0);
            check("burst_m1_stall", {30'd0, m_readyout}, 32'h1);
            tick();
        end
        drv(0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        push(1, 32'h500, 1'b0);
        mid();
        check("burst_after_grant", {31'd0, grant}, 32'd1);
        check("burst_after_ready", {30'd0, m_readyout}, 32'h3);
        tick();
        idle_all();
        tick();

        // Locked pair by m1 keeps m0 out until the lock drops.
        drv(1, 2'b10, 32'h600, 1'b0, 1'b1, 32'h0);
        push(1, 32'h600, 1'b0);
        mid();
        check("lock_grant_first", {31'd0, grant}, 32'd1);
        tick();
        drv(1, 2'b10, 32'h604, 1'b0, 1'b1, 32'h0);
        drv(0, 2'b10, 32'h700, 1'b0, 1'b0, 32'h0);
        push(1, 32'h604, 1'b0);
        mid();
        check("lock_grant_held", {31'd0, grant}, 32'd1);
        check("lock_m0_stall", {30'd0, m_readyout}, 32'h2);
        tick();
        drv(1, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        push(0, 32'h700, 1'b0);
        mid();
        check("lock_release_grant", {31'd0, grant}, 32'd0);
        tick();
        idle_all();
        tick();

        // m1 write with two wait states and a two-cycle ERROR; m0 waits throughout.
        drv(1, 2'b10, 32'h800, 1'b1, 1'b0, 32'h5555_0800);
        drv(0, 2'b10, 32'h900, 1'b0, 1'b0, 32'h0);
        push(1, 32'h800, 1'b1);
        mid();
        check("err_grant", {31'd0, grant}, 32'd1);
        check("err_m0_stall", {30'd0, m_readyout}, 32'h2);
        tick();
        drv(1, 2'b00, 32'h0, 1'b0, 1'b0, 32'h5555_0800);
        for (int w = 0; w < 2; w++) begin
            slv(1'b0, 1'b0, 32'h0);
            mid();
            check("wait_ready", {30'd0, m_readyout}, 32'h0);
            check("wait_resp", {30'd0, m_resp}, 32'h0);
            check("wait_hwdata", s_wdata, 32'h5555_0800);
            tick();
        end
        slv(1'b0, 1'b1, 32'h0);
        mid();
        check("err1_ready", {30'd0, m_readyout}, 32'h0);
        check("err1_resp", {30'd0, m_resp}, 32'h2);
        tick();
        slv(1'b1, 1'b1, 32'h0);
        push(0, 32'h900, 1'b0);
        mid();
        check("err2_ready", {30'd0, m_readyout}, 32'h3);
        check("err2_resp", {30'd0, m_resp}, 32'h2);
        check("err2_grant", {31'd0, grant}, 32'd0);
        tick();
        slv(1'b1, 1'b0, 32'h0);
        drv(0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        mid();
        check("err_done_resp", {30'd0, m_resp}, 32'h0);
        tick();

        // Reset in the middle of an m0 burst.
        drv(0, 2'b10, 32'hA00, 1'b0, 1'b0, 32'h0);
        push(0, 32'hA00, 1'b0);
        tick();
        drv(0, 2'b11, 32'hA04, 1'b0, 1'b0, 32'h0);
        push(0, 32'hA04, 1'b0);
        tick();
        HRESET = 1'b1;
        drv(0, 2'b11, 32'hA08, 1'b0, 1'b0, 32'h0);
        drv(1, 2'b10, 32'hB00, 1'b0, 1'b0, 32'h0);
        for (int r = 0; r < 2; r++) begin
            mid();
            check("mrst_ready", {30'd0, m_readyout}, 32'h3);
            check("mrst_htrans", {30'd0, s_trans}, 32'h0);
            check("mrst_hsel", {31'd0, s_sel}, 32'h0);
            check("mrst_grant", {31'd0, grant}, 32'd0);
            tick();
        end
        HRESET = 1'b0;
        idle_all();
        tick();
        // Pointer must be back at 0: m0 wins a tie again.
        drv(0, 2'b10, 32'hC00, 1'b0, 1'b0, 32'h0);
        drv(1, 2'b10, 32'hD00, 1'b0, 1'b0, 32'h0);
        push(0, 32'hC00, 1'b0);
        mid();
        check("post_rst_grant", {31'd0, grant}, 32'd0);
        check("post_rst_stall", {30'd0, m_readyout}, 32'h1);
        tick();
        drv(0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        push(1, 32'hD00, 1'b0);
        mid();
        check("post_rst_grant1", {31'd0, grant}, 32'd1);
        tick();
        idle_all();
        tick();
        mid();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
